// File: rtl/fdiv_seq.sv
// fdiv_seq: multi-cycle single-precision divider y = x1 / x2, restoring division, one quotient bit per cycle
// Ports: clk/rstn (async active-low reset); x1, x2, in_valid -> in_ready operand handshake;
// y, out_valid -> out_ready result handshake. No denormals, no NaN, truncated mantissa.
module fdiv_seq (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);
  typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;
  state_t state, nxt;
  logic              sy;
  logic        [7:0] e1, e2;
  logic       [23:0] d;
  logic       [25:0] r, rs;
  logic       [24:0] q, qn;
  logic        [4:0] cnt;
  logic              acc, special, ge;
  logic signed [9:0] ex;
  logic       [31:0] res, spec_y;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign acc       = in_ready && in_valid;
  assign special   = x1[30:23] == 8'd0 || x2[30:23] == 8'd0;
  assign spec_y    = x2[30:23] == 8'd0 ? {x1[31] ^ x2[31], 8'hff, 23'h0} : {x1[31] ^ x2[31], 31'h0};
  // qn includes the bit decided this cycle so the final iteration can normalise without an extra cycle
  always_comb begin
    ge  = r >= {2'b0, d};
    rs  = ge ? r - {2'b0, d} : r;
    qn  = {q[23:0], ge};
    ex  = {2'b0, e1} - {2'b0, e2} + (qn[24] ? 10'd127 : 10'd126);
    res = ex <= 10'sd0   ? {sy, 31'h0} :
          ex >= 10'sd255 ? {sy, 8'hff, 23'h0} :
                           {sy, ex[7:0], qn[24] ? qn[23:1] : qn[22:0]};
  end
  always_comb begin
    nxt = state;
    if (acc) nxt = special ? DONE : DIV;
    else if (state == DIV && cnt == 5'd0) nxt = DONE;
    else if (state == DONE && out_ready) nxt = IDLE;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      sy  <= 1'b0;
      e1  <= 8'd0;
      e2  <= 8'd0;
      d   <= 24'd0;
      r   <= 26'd0;
      q   <= 25'd0;
      cnt <= 5'd0;
      y   <= 32'd0;
    end else if (acc) begin
      sy  <= x1[31] ^ x2[31];
      e1  <= x1[30:23];
      e2  <= x2[30:23];
      d   <= {1'b1, x2[22:0]};
      r   <= {3'b001, x1[22:0]};
      q   <= 25'd0;
      cnt <= 5'd24;
      if (special) y <= spec_y;
    end else if (state == DIV) begin
      r   <= {rs[24:0], 1'b0};
      q   <= qn;
      cnt <= cnt - 5'd1;
      if (cnt == 5'd0) y <= res;
    end
endmodule

// File: tb/tb_fdiv_seq.sv
// tb_fdiv_seq: directed and random checks of fdiv_seq results, latency, backpressure and reset
module tb_fdiv_seq;
  logic        clk = 0, rstn = 0, in_valid = 0, out_ready = 0;
  logic [31:0] x1 = 0, x2 = 0;
  logic        in_ready, out_valid;
  logic [31:0] y;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  fdiv_seq dut (
    .clk(clk), .rstn(rstn), .x1(x1), .x2(x2), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .out_valid(out_valid), .out_ready(out_ready)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e1, e2, ex;
    longint      qq;
    logic [63:0] qv;
    logic [22:0] my;
    s  = a[31] ^ b[31];
    e1 = int'(a[30:23]);
    e2 = int'(b[30:23]);
    if (e2 == 0) return {s, 8'hff, 23'h0};
    if (e1 == 0) return {s, 31'h0};
    qq = (longint'({1'b1, a[22:0]}) << 24) / longint'({1'b1, b[22:0]});
    qv = 64'(qq);
    if (qq >= 64'd16777216) begin my = qv[23:1]; ex = e1 - e2 + 127; end
    else begin my = qv[22:0]; ex = e1 - e2 + 126; end
    if (ex <= 0) return {s, 31'h0};
    if (ex >= 255) return {s, 8'hff, 23'h0};
    return {s, 8'(ex), my};
  endfunction
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int exp_lat, input bit pulse, input int hold);
    int          lat;
    logic [31:0] yh;
    @(negedge clk);
    chk({tag, " in_ready idle"}, 32'(in_ready), 32'd1);
    x1 = a; x2 = b; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; x1 = $urandom; x2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 60) begin
      if (pulse) begin in_valid = lat[0]; x1 = $urandom; x2 = $urandom; end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 0;
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " y"}, y, exp);
    yh = y;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, " y held"}, y, yh);
      chk({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
      chk({tag, " out_valid held"}, 32'(out_valid), 32'd1);
    end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    chk({tag, " in_ready after"}, 32'(in_ready), 32'd1);
    chk({tag, " out_valid after"}, 32'(out_valid), 32'd0);
  endtask
  initial begin
    logic [31:0] a, b;
    #1;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset y", y, 32'd0);
    @(negedge clk); rstn = 1;
    run("6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 0, 0);
    run("1/3", 32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 26, 0, 0);
    run("0/-2", 32'h00000000, 32'hC0000000, 32'h80000000, 1, 0, 0);
    run("1/0", 32'h3F800000, 32'h00000000, 32'h7F800000, 1, 0, 0);
    run("underflow", 32'h00800000, 32'h40000000, 32'h00000000, 26, 0, 0);
    run("overflow", 32'h7F000000, 32'h3F000000, 32'h7F800000, 26, 0, 0);
    run("backpressure", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 1, 10);
    @(negedge clk);
    x1 = 32'h40C00000; x2 = 32'h40000000; in_valid = 1;
    @(posedge clk); #1 in_valid = 0;
    repeat (11) @(posedge clk);
    #1 rstn = 0;
    #1;
    chk("midreset out_valid", 32'(out_valid), 32'd0);
    chk("midreset y", y, 32'd0);
    chk("midreset in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(negedge clk);
    rstn = 1;
    repeat (30) begin
      @(posedge clk); #1;
      chk("post-reset idle", 32'(out_valid), 32'd0);
    end
    run("after reset 6/2", 32'h40C00000, 32'h40000000, 32'h40400000, 26, 0, 0);
    for (int k = 0; k < 1000; k++) begin
      a = {1'($urandom), 8'($urandom_range(1, 254)), 23'($urandom)};
      b = {1'($urandom), 8'($urandom_range(k[0] ? 64 : 1, k[0] ? 190 : 254)), 23'($urandom)};
      run("random", a, b, ref_div(a, b), 26, k[1], 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
